// File: rtl/register_file.sv
// rtl/register_file.sv - 2-read/1-write register file, optional REGFILE_BYPASS_EN write-through forwarding
module register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = 64,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] Read1,
    input  logic [ADDR_W-1:0] Read2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] Data1,
    output logic [DATA_W-1:0] Data2
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              write_allowed;

    assign write_allowed = RegWrite && !((ZERO_REG != 0) && (WriteReg == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_allowed) begin
            regs[WriteReg] <= WriteData;
        end
    end

    // Index 0 is masked on the read side so its storage contents never matter.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] value;
        value = regs[idx];
        if ((ZERO_REG != 0) && (idx == '0)) begin
            value = '0;
        end
`ifdef REGFILE_BYPASS_EN
        if (rst_n && write_allowed && (idx == WriteReg)) begin
            value = WriteData;
        end
`endif
        return value;
    endfunction

    always_comb begin
        Data1 = read_port(Read1);
        Data2 = read_port(Read2);
    end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized reference-model bench for register_file
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic        RegWrite;
    logic [5:0]  Read1;
    logic [5:0]  Read2;
    logic [5:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] Data1;
    logic [31:0] Data2;

    int total;
    int bad;

    logic [31:0] model [64];

    register_file dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RegWrite (RegWrite),
        .Read1    (Read1),
        .Read2    (Read2),
        .WriteReg (WriteReg),
        .WriteData(WriteData),
        .Data1    (Data1),
        .Data2    (Data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Expected read value from the architectural rules, including same-cycle forwarding when built with it.
    function automatic logic [31:0] exp_read(input logic [5:0] idx);
        logic [31:0] v;
        v = (idx == 6'd0) ? 32'h0 : model[idx];
`ifdef REGFILE_BYPASS_EN
        if (rst_n && RegWrite && idx == WriteReg && idx != 6'd0) v = WriteData;
`endif
        return v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) begin
            foreach (model[i]) model[i] = 32'h0;
        end else if (RegWrite && WriteReg != 6'd0) begin
            model[WriteReg] = WriteData;
        end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        RegWrite = 1'b0;
        Read1 = '0;
        Read2 = '0;
        WriteReg = '0;
        WriteData = '0;
        @(negedge clk);

        cycle();
        rst_n = 1'b1;
        Read1 = 6'd5;
        Read2 = 6'd63;
        #1;
        check("reset_d1", Data1, 32'h0);
        check("reset_d2", Data2, 32'h0);

        RegWrite = 1'b1; WriteReg = 6'd7; WriteData = 32'hDEADBEEF;
        cycle();
        RegWrite = 1'b0; Read1 = 6'd7; Read2 = 6'd7;
        #1;
        check("wr7_d1", Data1, 32'hDEADBEEF);
        check("wr7_d2", Data2, 32'hDEADBEEF);

        RegWrite = 1'b1; WriteReg = 6'd0; WriteData = 32'h12345678;
        cycle();
        RegWrite = 1'b0; Read1 = 6'd0;
        #1;
        check("zero_reg", Data1, 32'h0);

        RegWrite = 1'b1; WriteReg = 6'd63; WriteData = 32'hAAAA5555;
        cycle();
        RegWrite = 1'b0; Read2 = 6'd63;
        #1;
        check("top_idx", Data2, 32'hAAAA5555);

        RegWrite = 1'b0; WriteReg = 6'd3; WriteData = 32'hFFFFFFFF;
        cycle();
        Read1 = 6'd3;
        #1;
        check("we_gate", Data1, 32'h0);

        RegWrite = 1'b1; WriteReg = 6'd9; WriteData = 32'h11111111;
        cycle();
        WriteData = 32'h22222222; Read1 = 6'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_before", Data1, 32'h22222222);
`else
        check("rdw_before", Data1, 32'h11111111);
`endif
        cycle();
        RegWrite = 1'b0;
        #1;
        check("rdw_after", Data1, 32'h22222222);

        rst_n = 1'b0; RegWrite = 1'b1; WriteReg = 6'd4; WriteData = 32'hCAFEF00D;
        cycle();
        rst_n = 1'b1; RegWrite = 1'b0; Read1 = 6'd4; Read2 = 6'd7;
        #1;
        check("rst_prio", Data1, 32'h0);
        check("rst_clr7", Data2, 32'h0);

        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            RegWrite  = $urandom_range(0, 1);
            WriteReg  = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            WriteData = $urandom;
            Read1     = ($urandom_range(0, 2) == 0) ? WriteReg : 6'($urandom_range(0, 7));
            Read2     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
            #1;
            check("rnd_d1", Data1, exp_read(Read1));
            check("rnd_d2", Data2, exp_read(Read2));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
